// File: rtl/mult_seq_disp.sv
// Sequential shift-and-add unsigned multiplier started by a push button.
// The product is also held as two 4-bit digits for a two-digit seven-segment driver.
module mult_seq_disp #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_btn,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [3:0]     val1,
    output logic [3:0]     val2
);

    localparam int CW = (N > 2) ? 2 : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    state_e         state_q;
    logic           s1_q, s2_q, s3_q;
    logic [2*N-1:0] mcand_q;
    logic [N-1:0]   mplier_q;
    logic [2*N-1:0] acc_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [2*N-1:0] product_q;
    logic [7:0]     disp_q;

    logic           start_pulse;
    logic [2*N-1:0] acc_d;

    assign start_pulse = s2_q & ~s3_q;
    assign acc_d       = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            // NOTE: synchronizer resets to 1 so a button held through reset release reads as no edge.
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s3_q      <= 1'b1;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            disp_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop see the pre-edge values of the others.
            s1_q   <= start_btn;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_pulse) begin
                        mcand_q  <= {{N{1'b0}}, a};
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    // Last partial product: publish the sum directly rather than waiting a cycle.
                    if (cnt_q == CW'(N - 1)) begin
                        product_q <= acc_d;
                        disp_q    <= 8'(acc_d);
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign val1    = disp_q[7:4];
    assign val2    = disp_q[3:0];

endmodule

// File: tb/tb_mult_seq_disp.sv
// Directed and exhaustive bench for mult_seq_disp; expected products flow
// through a scoreboard queue from press to done.
module tb_mult_seq_disp;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_btn = 1'b0;
    logic [N-1:0]   a = '0;
    logic [N-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;
    logic [3:0]     val1;
    logic [3:0]     val2;

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    mult_seq_disp #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_btn(start_btn),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .val1     (val1),
        .val2     (val2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation: press, scramble operands once busy, check latency and result.
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv);
        int         n;
        int         load_n;
        int         done_n;
        logic       extra;
        logic [7:0] e;
        n      = 0;
        load_n = 0;
        done_n = 0;
        extra  = 1'b0;
        @(negedge clk);
        a = av;
        b = bv;
        start_btn = 1'b1;
        e = av * bv;
        sb.push_back(e);
        while (done_n == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy && load_n == 0) begin
                load_n = n;
                a = ~av;
                b = ~bv;
            end
            if (done) done_n = n;
        end
        check("load_latency", load_n, 3);
        check("done_latency", done_n, N + 3);
        e = sb.pop_front();
        check("product", product, e);
        check("val1", val1, e[7:4]);
        check("val2", val2, e[3:0]);
        check("busy_at_done", busy, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("no_reload_held_btn", busy, 0);
        start_btn = 1'b0;
        repeat (4) begin
            @(negedge clk);
            extra = extra | done | busy;
        end
        check("no_second_op", extra, 0);
    endtask

    initial begin
        int   n;
        logic flag;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        check("rst_val1", val1, 0);
        check("rst_val2", val2, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd3, 4'd5);
        run_op(4'hF, 4'hF);
        run_op(4'h0, 4'h9);
        run_op(4'h9, 4'h0);
        run_op(4'h7, 4'hB);

        // Button held through reset release must not start anything.
        rst_n = 1'b0;
        start_btn = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            flag = flag | busy | done;
        end
        check("held_through_reset", flag, 0);
        start_btn = 1'b0;
        repeat (4) @(negedge clk);
        run_op(4'd2, 4'd7);

        // Reset in the middle of a calculation.
        run_op(4'd3, 4'd5);
        @(negedge clk);
        a = 4'hF;
        b = 4'hF;
        start_btn = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_busy", busy, 1);
        check("abort_prior", product, 8'h0F);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_product", product, 0);
        check("abort_val1", val1, 0);
        check("abort_val2", val2, 0);
        check("abort_busy_clr", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        start_btn = 1'b0;
        flag = 1'b0;
        repeat (12) begin
            @(negedge clk);
            flag = flag | busy | done;
        end
        check("abort_idle", flag, 0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j));
            end
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_seq_disp.md
Name: mult_seq_disp

Overview:
- Sequential unsigned shift-and-add multiplier that computes a×b from switch operands on a start button press.
- Holds the product as two 4-bit digits for the two-digit seven-segment display driver directly downstream: `val1` is the high digit, `val2` is the low digit.
- Includes a button synchronizer/edge detector, a small FSM and a registered result.

Parameters:
- N, 4, operand width in bits; legal range 2..4. The product is 2N bits and is zero-extended to 8 bits for display.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- start_btn  input  1  raw, asynchronous start button (level)
- a  input  N  multiplicand (switches); sampled only at operation load
- b  input  N  multiplier (switches); sampled only at operation load
- busy  output  1  high while a multiplication is in progress
- done  output  1  one-cycle pulse when a new product is written
- product  output  2N  registered result of the last completed operation
- val1  output  4  display digit, high = product zero-extended to 8 bits, bits [7:4]
- val2  output  4  display digit, low = product zero-extended to 8 bits, bits [3:0]

Behaviour:
- Reset (rst_n=0, immediate, regardless of clk):
  - state=IDLE; busy=0, done=0, product=0, val1=0, val2=0.
  - Internal accumulator, shift registers and bit counter = 0.
  - Synchronizer flops s1, s2, s3 = 1, so a button held through reset release does not start an operation; it must be released and pressed again.
- Synchronizer / edge detect:
  - On each edge: s1<=start_btn, s2<=s1, s3<=s2.
  - start_pulse = s2 & ~s3, a one-cycle pulse.
  - If start_btn rises before edge k, start_pulse is high between edges k+1 and k+2.
- FSM states: IDLE, CALC.
- IDLE:
  - busy=0.
  - On an edge with start_pulse=1: load mcand<=zero-extend(a) to 2N bits, mplier<=b, acc<=0, cnt<=0; go to CALC.
  - With the timing above, the load happens at edge k+2.
- CALC, busy=1, exactly N edges:
  - acc_next = acc + (mplier[0] ? mcand : 0), computed mod 2^(2N). It cannot overflow for unsigned operands.
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1; acc<=acc_next.
- Final CALC edge (cnt==N-1):
  - product<=acc_next; val1/val2 update from acc_next at the same edge; done<=1; state<=IDLE.
- Latency and throughput:
  - The product is valid N edges after the load edge, i.e. edge k+2+N for a button edge before k.
  - done is high for exactly one cycle and is cleared on the next edge.
  - Minimum spacing between operations is N+1 cycles after the load.
- Outputs between operations:
  - product, val1 and val2 hold their value until the next completion; there is no intermediate value during CALC.
- start_pulse while busy=1: ignored and not queued. A single press spanning busy yields no second operation.
- start_pulse on the same cycle that done is asserted (state already IDLE): accepted, and a new load occurs at that edge.
- a/b changes during CALC: ignored; the operands latched at load are used.
- Reset asserted mid-CALC: operation aborted, all outputs back to reset values, no done pulse.
- N<4:
  - val1 = upper nibble of the zero-extended product; for N=2 it is always 0.
  - Unused bits are 0.

Test Plan:
- Reset, then a=4'd3, b=4'd5, press start_btn before edge 10 and hold: busy goes 1 after edge 12; done pulses after edge 16; product=8'h0F, val1=0, val2=4'hF.
- a=4'hF, b=4'hF: product=8'hE1, val1=4'hE, val2=4'h1; then a=0, b=4'h9 on a new press: product=0, val1=0, val2=0. Also check b=0 and a=0 cases.
- Hold start_btn high through reset release: no operation occurs and busy stays 0. Release, then press: exactly one operation runs.
- Press again and toggle a/b while busy=1: result uses the originally loaded operands; no second done pulse occurs.
- Assert rst_n low for one half-cycle mid-CALC after a prior result of 8'h0F: product, val1 and val2 go 0 immediately, done never pulses, and the FSM is idle afterwards.
- Exhaustive sweep of all 256 (a,b) pairs with self-checking: product==a*b, {val1,val2}==product, each done pulse is one cycle, and the load-to-done distance is exactly N cycles.
